// File: rtl/multiplicador_pkg.sv
// Shared definitions for the shift-add reconstruction unit and its sibling divider.
// The state encodings are kept stable so both blocks decode states the same way.
package multiplicador_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Iteration counter must be able to hold WIDTH itself.
  function automatic int countWidth(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/multiplicador.sv
// Sequential shift-add unit: portA = portQ * portB + portR, one multiplier bit per cycle,
// with a START-edge / DONE-pulse handshake matching the divider.
module multiplicador
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 START,
  input  logic [WIDTH-1:0]     portQ,
  input  logic [WIDTH-1:0]     portB,
  input  logic [WIDTH-1:0]     portR,
  output logic [2*WIDTH-1:0]   portA,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int CW = countWidth(WIDTH);
  localparam int RW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    mb_q, mb_d;
  logic [RW-1:0]    portA_q, portA_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [CW-1:0]    count_q, count_d;
  logic             start_q;
  logic             busy_q, busy_d;
  logic             trigger;
  logic [RW-1:0]    accSum;

  assign trigger = START && !start_q;
  // The result can never exceed 2^(2W) - 2^W, so truncation to RW bits loses nothing.
  assign accSum  = mq_q[0] ? (acc_q + mb_q) : acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mb_d    = mb_q;
    mq_d    = mq_q;
    count_d = count_q;
    portA_d = portA_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          acc_d   = {{WIDTH{1'b0}}, portR};
          mb_d    = {{WIDTH{1'b0}}, portB};
          mq_d    = portQ;
          count_d = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = accSum;
        mq_d    = mq_q >> 1;
        mb_d    = mb_q << 1;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          portA_d = accSum;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mb_q    <= '0;
      mq_q    <= '0;
      count_q <= '0;
      portA_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mb_q    <= mb_d;
      mq_q    <= mq_d;
      count_q <= count_d;
      portA_q <= portA_d;
      start_q <= START;
      busy_q  <= busy_d;
    end
  end

  assign portA = portA_q;
  assign BUSY  = busy_q;
  assign DONE  = (state_q == FIN);

endmodule

// File: tb/tb_multiplicador.sv
// Directed bench for multiplicador (WIDTH=3): hand-computed Q*B+R results, DONE/BUSY timing,
// START edge handling, input sampling and asynchronous reset.
module tb_multiplicador;

  logic       clk;
  logic       rst_n;
  logic       START;
  logic [2:0] portQ;
  logic [2:0] portB;
  logic [2:0] portR;
  logic [5:0] portA;
  logic       BUSY;
  logic       DONE;

  int total = 0;
  int bad   = 0;

  multiplicador #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .START (START),
    .portQ (portQ),
    .portB (portB),
    .portR (portR),
    .portA (portA),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called just after a negedge: drops START for one cycle, then raises it with new operands
  // so the next posedge is the trigger edge k.
  task automatic applyStimulus(input logic [2:0] q, input logic [2:0] b, input logic [2:0] r);
    START = 1'b0;
    @(negedge clk);
    portQ = q;
    portB = b;
    portR = r;
    START = 1'b1;
  endtask

  // First negedge after trigger edge k.
  task automatic checkFirst(input string tag);
    @(negedge clk);
    checkOutput({tag, ".busyK"}, 32'(BUSY), 32'd1);
    checkOutput({tag, ".doneK"}, 32'(DONE), 32'd0);
  endtask

  // Remaining cycles: k+1, k+2 (no DONE, old result held), k+3 (DONE, result), k+4 (idle).
  task automatic checkRest(input string tag, input logic [5:0] expA, input logic [5:0] prevA);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checkOutput({tag, ".doneEarly"}, 32'(DONE), 32'd0);
      checkOutput({tag, ".holdA"}, 32'(portA), 32'(prevA));
    end
    @(negedge clk);
    checkOutput({tag, ".done"}, 32'(DONE), 32'd1);
    checkOutput({tag, ".portA"}, 32'(portA), 32'(expA));
    checkOutput({tag, ".busyFin"}, 32'(BUSY), 32'd1);
    @(negedge clk);
    checkOutput({tag, ".doneOff"}, 32'(DONE), 32'd0);
    checkOutput({tag, ".busyOff"}, 32'(BUSY), 32'd0);
    checkOutput({tag, ".portAHold"}, 32'(portA), 32'(expA));
  endtask

  initial begin
    rst_n = 1'b0;
    START = 1'b0;
    portQ = '0;
    portB = '0;
    portR = '0;

    #2;
    checkOutput("reset.portA", 32'(portA), 32'd0);
    checkOutput("reset.busy", 32'(BUSY), 32'd0);
    checkOutput("reset.done", 32'(DONE), 32'd0);
    #10 rst_n = 1'b1;

    // 1*5+2 = 7, START rises at t=18 and stays high; trigger edge at t=25.
    #6;
    portQ = 3'd1;
    portB = 3'd5;
    portR = 3'd2;
    START = 1'b1;
    @(negedge clk);
    checkOutput("first.busyBefore", 32'(BUSY), 32'd0);
    checkFirst("first");
    checkRest("first", 6'd7, 6'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("held.noDone", 32'(DONE), 32'd0);
      checkOutput("held.noBusy", 32'(BUSY), 32'd0);
    end

    // Back-to-back: 3*3+1 = 10, old result held until the new DONE.
    applyStimulus(3'd3, 3'd3, 3'd1);
    checkFirst("b2b");
    checkRest("b2b", 6'd10, 6'd7);

    // 7*7+7 = 56 (near the maximum).
    applyStimulus(3'd7, 3'd7, 3'd7);
    checkFirst("max");
    checkRest("max", 6'd56, 6'd10);

    // Q=0: 0*6+4 = 4.
    applyStimulus(3'd0, 3'd6, 3'd4);
    checkFirst("qzero");
    checkRest("qzero", 6'd4, 6'd56);

    // B=0: 5*0+3 = 3.
    applyStimulus(3'd5, 3'd0, 3'd3);
    checkFirst("bzero");
    checkRest("bzero", 6'd3, 6'd4);

    // Operands change after the trigger edge; result must use sampled 1*5+2 = 7.
    applyStimulus(3'd1, 3'd5, 3'd2);
    checkFirst("sampled");
    portB = 3'd2;
    portQ = 3'd6;
    portR = 3'd0;
    checkRest("sampled", 6'd7, 6'd3);

    // START toggles low-high mid-run: 2*3+0 = 6, exactly one DONE.
    applyStimulus(3'd2, 3'd3, 3'd0);
    checkFirst("toggle");
    START = 1'b0;
    @(negedge clk);
    checkOutput("toggle.done1", 32'(DONE), 32'd0);
    START = 1'b1;
    @(negedge clk);
    checkOutput("toggle.done2", 32'(DONE), 32'd0);
    @(negedge clk);
    checkOutput("toggle.done", 32'(DONE), 32'd1);
    checkOutput("toggle.portA", 32'(portA), 32'd6);
    @(negedge clk);
    checkOutput("toggle.busyOff", 32'(BUSY), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("toggle.noSecondDone", 32'(DONE), 32'd0);
      checkOutput("toggle.noSecondBusy", 32'(BUSY), 32'd0);
    end

    // Reset asserted just after edge k+2 of a 7*7+7 run: outputs clear without a clock.
    applyStimulus(3'd7, 3'd7, 3'd7);
    checkFirst("rst");
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    START = 1'b0;
    #1;
    checkOutput("rst.portA", 32'(portA), 32'd0);
    checkOutput("rst.busy", 32'(BUSY), 32'd0);
    checkOutput("rst.done", 32'(DONE), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst.idleBusy", 32'(BUSY), 32'd0);
    checkOutput("rst.idleA", 32'(portA), 32'd0);

    // Fresh operation after reset: 3*3+1 = 10.
    applyStimulus(3'd3, 3'd3, 3'd1);
    checkFirst("after");
    checkRest("after", 6'd10, 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
